// File: rtl/router_pkg.sv
// Shared constants for the router synchronizer: port count, idle timeout,
// and the two-bit destination address encodings carried in header bits [1:0].
package router_pkg;

  localparam int NUM_PORTS      = 3;
  localparam int TIMEOUT_CYCLES = 30;
  localparam int CNT_W          = 5;

  localparam logic [1:0] ADDR_P0      = 2'b00;
  localparam logic [1:0] ADDR_P1      = 2'b01;
  localparam logic [1:0] ADDR_P2      = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // One-hot FIFO select for a destination address; the invalid address selects nothing.
  function automatic logic [NUM_PORTS-1:0] addr_decode(input logic [1:0] addr);
    logic [NUM_PORTS-1:0] sel;
    case (addr)
      ADDR_P0: sel = 3'b001;
      ADDR_P1: sel = 3'b010;
      ADDR_P2: sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port idle watchdog: counts consecutive edges where the port holds valid
// data that nobody reads, and emits a one-cycle registered soft-reset pulse on
// the TIMEOUT_CYCLES-th such edge. The count never wraps past TIMEOUT_CYCLES-1.
module router_sync_timer
  import router_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt_r;
  logic             soft_reset_r;
  logic             idle_s;
  logic             expire_s;

  // Decode whether this edge extends the idle run and whether it ends it.
  always_comb begin
    idle_s   = 1'b0;
    expire_s = 1'b0;
    if (vld && !read_enb) begin
      idle_s   = 1'b1;
      expire_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin
      idle_s   = 1'b0;
      expire_s = 1'b0;
    end
  end

  // Idle counter and soft-reset pulse register; expiry restarts the count from zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_r        <= '0;
      soft_reset_r <= 1'b0;
    end else if (!idle_s) begin
      cnt_r        <= '0;
      soft_reset_r <= 1'b0;
    end else if (expire_s) begin
      cnt_r        <= '0;
      soft_reset_r <= 1'b1;
    end else begin
      cnt_r        <= cnt_r + 5'd1;
      soft_reset_r <= 1'b0;
    end
  end

  assign soft_reset = soft_reset_r;

endmodule

// File: rtl/router_sync.sv
// Router synchronizer: latches the destination address from the header byte,
// steers the FSM write request to one FIFO, reports that FIFO's full flag, and
// exposes per-destination valid flags.
// Optional feature macro: SOFT_RESET_TIMEOUT_EN -- when defined, each port gets
// an idle watchdog that pulses soft_reset_x after TIMEOUT_CYCLES unread edges;
// otherwise soft_reset_0/1/2 are constant zero and no counters exist.
module router_sync
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  logic [1:0]           addr_r;
  logic [NUM_PORTS-1:0] vld_s;
  logic [NUM_PORTS-1:0] rd_s;
  logic [NUM_PORTS-1:0] soft_s;

  assign vld_s = {~empty_2, ~empty_1, ~empty_0};
  assign rd_s  = {read_enb_2, read_enb_1, read_enb_0};

  // Address register: captures header bits on detect_add; a same-edge write still uses the old value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_r <= ADDR_INVALID;
    end else if (detect_add) begin
      addr_r <= data_in;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Write steering and full-flag selection from the latched address.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    if (write_enb_reg) begin
      write_enb = addr_decode(addr_r);
    end else begin
      write_enb = 3'b000;
    end
    case (addr_r)
      ADDR_P0: fifo_full = full_0;
      ADDR_P1: fifo_full = full_1;
      ADDR_P2: fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

`ifdef SOFT_RESET_TIMEOUT_EN
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timer
    router_sync_timer u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_s[p]),
      .read_enb   (rd_s[p]),
      .soft_reset (soft_s[p])
    );
  end
`else
  logic [NUM_PORTS-1:0] unused_rd_s;
  assign unused_rd_s = rd_s;
  assign soft_s      = '0;
`endif

  assign vld_out_0    = vld_s[0];
  assign vld_out_1    = vld_s[1];
  assign vld_out_2    = vld_s[2];
  assign soft_reset_0 = soft_s[0];
  assign soft_reset_1 = soft_s[1];
  assign soft_reset_2 = soft_s[2];

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: expected output vectors are pushed to a
// scoreboard as stimulus is applied and popped when the outputs are sampled.
module tb_router_sync;

`ifdef SOFT_RESET_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  typedef struct {
    string      tag;
    logic [9:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] exp_addr;
  logic [9:0] obs;
  int         checks = 0;
  int         errors = 0;

  router_sync dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  always #5 clock = ~clock;

  assign obs = {write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
                soft_reset_2, soft_reset_1, soft_reset_0};

  // Expected output vector from the bench's view of the address and current inputs.
  function automatic logic [9:0] model(input logic [1:0] a, input logic [2:0] sr);
    logic [2:0] we;
    logic       ff;
    case (a)
      2'b00:   begin we = 3'b001; ff = full_0; end
      2'b01:   begin we = 3'b010; ff = full_1; end
      2'b10:   begin we = 3'b100; ff = full_2; end
      default: begin we = 3'b000; ff = 1'b0;   end
    endcase
    if (!write_enb_reg) we = 3'b000;
    return {we, ff, ~empty_2, ~empty_1, ~empty_0, sr};
  endfunction

  task automatic push_exp(input string tag, input logic [2:0] sr);
    exp_t e;
    e.tag = tag;
    e.val = model(exp_addr, sr);
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.val)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
    end
  endtask

  // Combinational check: no clock edge between stimulus and sample.
  task automatic now_check(input string tag, input logic [2:0] sr);
    push_exp(tag, sr);
    #1;
    check_front();
  endtask

  // Clocked check: sample 1 time unit after the next rising edge.
  task automatic edge_check(input string tag, input logic [2:0] sr);
    push_exp(tag, sr);
    @(posedge clock);
    #1;
    check_front();
  endtask

  initial begin
    logic [2:0] sr;
    resetn = 1'b0; detect_add = 1'b1; data_in = 2'b01; write_enb_reg = 1'b1;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    exp_addr = 2'b11;

    // Reset: header strobe ignored, outputs idle, vld tracks empty.
    edge_check("reset_hold", 3'b000);
    edge_check("reset_hold2", 3'b000);
    empty_1 = 1'b0;
    now_check("reset_vld1", 3'b000);
    empty_1 = 1'b1;
    detect_add = 1'b0; write_enb_reg = 1'b0;
    resetn = 1'b1;
    now_check("release_idle", 3'b000);

    // Address latch and write steering.
    detect_add = 1'b1; data_in = 2'b10;
    exp_addr = 2'b10;
    edge_check("latch_p2_noreq", 3'b000);
    detect_add = 1'b0; write_enb_reg = 1'b1;
    now_check("wr_p2", 3'b000);
    full_2 = 1'b1;
    now_check("full_p2", 3'b000);
    full_2 = 1'b0; full_0 = 1'b1;
    now_check("full_other", 3'b000);

    // Same-edge header and write: old address in the cycle, new after the edge.
    detect_add = 1'b1; data_in = 2'b00;
    now_check("same_edge_pre", 3'b000);
    exp_addr = 2'b00;
    edge_check("same_edge_post", 3'b000);
    data_in = 2'b01; full_1 = 1'b1;
    exp_addr = 2'b01;
    edge_check("latch_p1", 3'b000);
    data_in = 2'b11;
    exp_addr = 2'b11;
    edge_check("latch_invalid", 3'b000);
    detect_add = 1'b0; write_enb_reg = 1'b0;
    full_0 = 1'b0; full_1 = 1'b0;

    // Port 0 idle timeout, then a second period to show the count restarts.
    empty_0 = 1'b0;
    for (int k = 1; k <= 61; k++) begin
      sr = 3'b000;
      sr[0] = TO_EN && (k % 30 == 0);
      edge_check($sformatf("timeout0_edge%0d", k), sr);
    end
    empty_0 = 1'b1;

    // Port 1: read at edge 20 restarts the count; pulse at edge 50.
    empty_1 = 1'b0;
    for (int k = 1; k <= 51; k++) begin
      read_enb_1 = (k == 20);
      sr = 3'b000;
      sr[1] = TO_EN && (k == 50);
      edge_check($sformatf("timeout1_edge%0d", k), sr);
    end
    read_enb_1 = 1'b0;
    empty_1 = 1'b1;

    // Ports 0 and 2 time out on the same edge.
    empty_0 = 1'b0; empty_2 = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      sr = (TO_EN && k == 30) ? 3'b101 : 3'b000;
      edge_check($sformatf("timeout02_edge%0d", k), sr);
    end

    // Reset at edge 15 of a count discards it and clears the address asynchronously.
    detect_add = 1'b1; data_in = 2'b00; write_enb_reg = 1'b1;
    exp_addr = 2'b00;
    edge_check("midcount_latch_p0", 3'b000);
    detect_add = 1'b0;
    for (int k = 2; k <= 15; k++) begin
      edge_check($sformatf("midcount_edge%0d", k), 3'b000);
    end
    resetn = 1'b0;
    exp_addr = 2'b11;
    now_check("async_reset", 3'b000);
    #1;
    resetn = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      sr = (TO_EN && k == 30) ? 3'b101 : 3'b000;
      edge_check($sformatf("post_reset_edge%0d", k), sr);
    end

    checks++;
    assert (sb.size() === 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_sync.md
ROUTER_SYNC -- requirements
Module: router_sync

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: detect_add  in  1  header-byte strobe from control FSM.
REQ-004 SHALL have ports: data_in  in  2  destination address (header bits [1:0]).
REQ-005 SHALL have ports: write_enb_reg  in  1  FSM write request.
REQ-006 SHALL have ports: read_enb_0/1/2  in  1 each  destination read enables.
REQ-007 SHALL have ports: empty_0/1/2, full_0/1/2  in  1 each  FIFO status flags.
REQ-008 SHALL have ports: write_enb  out  3  one-hot FIFO write enables.
REQ-009 SHALL have ports: fifo_full  out  1  full flag of the addressed FIFO.
REQ-010 SHALL have ports: vld_out_0/1/2  out  1 each  destination data valid.
REQ-011 SHALL have ports: soft_reset_0/1/2  out  1 each  per-FIFO soft-reset pulses.

Function
REQ-012 SHALL latch data_in into a 2-bit address register on a rising edge where detect_add=1; otherwise hold.
REQ-013 SHALL drive write_enb combinationally: addr 00->001, 01->010, 10->100, 11->000; all zero when write_enb_reg=0.
REQ-014 SHALL drive fifo_full combinationally as full_<addr>; 0 for addr 11.
REQ-015 SHALL drive vld_out_x = ~empty_x combinationally.
REQ-016 Same-edge detect_add and write_enb_reg: the write in that cycle SHALL use the previously latched address.
REQ-017 Per port, a 5-bit idle counter SHALL clear when vld_out_x=0 or read_enb_x=1, else increment by 1.
REQ-018 When the counter equals TIMEOUT_CYCLES-1 (29) and the increment condition holds, soft_reset_x SHALL be registered high for exactly one cycle and the counter SHALL return to 0.
REQ-019 soft_reset_x SHALL therefore assert on the 30th consecutive edge with vld_out_x=1 and read_enb_x=0; a read_enb_x pulse on any earlier edge SHALL restart the count.
REQ-020 The three port timers SHALL run independently and SHALL be able to pulse on the same edge.
REQ-021 Counter SHALL never wrap; maximum value reached is 29.

Reset
REQ-022 On resetn=0, asynchronously: address register = 2'b11, all counters = 0, soft_reset_0/1/2 = 0.
REQ-023 During reset, write_enb SHALL be 000 and fifo_full 0 (follows from address 11); vld_out_x SHALL still track empty_x.
REQ-024 Reset mid-count SHALL discard the partial count; counting restarts from 0 after release.

Configuration
REQ-025 With SOFT_RESET_TIMEOUT_EN defined, REQ-017..REQ-021 SHALL be implemented.
REQ-026 Without SOFT_RESET_TIMEOUT_EN, soft_reset_0/1/2 SHALL be tied to 0, no counters synthesized; all other behaviour unchanged.

Structure
REQ-027 Shared package router_pkg SHALL hold TIMEOUT_CYCLES (30), NUM_PORTS (3), address encodings ADDR_P0/P1/P2/INVALID.
REQ-028 Idle counter plus pulse register SHALL be one sub-module, router_sync_timer, instantiated once per port.

Verification
REQ-029 resetn low, detect_add=1, data_in=01 -> address stays 11, write_enb=000, soft_reset all 0.
REQ-030 detect_add=1 with data_in=10, then write_enb_reg=1 -> write_enb=100; full_2=1 -> fifo_full=1; data_in=11 latched -> write_enb=000, fifo_full=0.
REQ-031 empty_0=0, read_enb_0=0 for 30 edges -> soft_reset_0 high for exactly one cycle after 30th edge, low after; counter restarts.
REQ-032 empty_1=0, read_enb_1 pulsed at edge 20 -> no soft_reset_1 until 30 further idle edges (edge 50).
REQ-033 empty_0=empty_2=0, both idle 30 edges -> soft_reset_0 and soft_reset_2 pulse on same edge; resetn pulsed at edge 15 of a count -> no pulse until 30 edges after release.
REQ-034 Build without SOFT_RESET_TIMEOUT_EN, repeat REQ-031 -> soft_reset_0 stays 0.
